// File: rtl/prog_fetch_pkg.sv
// Shared types and default constants for the program-fetch sequencer.
package prog_fetch_pkg;

  localparam int PROG_ADDR_W = 4;
  localparam int PROG_DATA_W = 8;
  localparam logic [PROG_DATA_W-1:0] PROG_HALT_OPCODE = 8'hFF;

  typedef logic [PROG_ADDR_W-1:0] pc_t;
  typedef logic [PROG_DATA_W-1:0] instr_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/prog_pc_reg.sv
// Program counter register: synchronous load has priority over increment,
// otherwise the value is held. Increment wraps modulo 2^ADDR_W.
module prog_pc_reg
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] pc_d, pc_q;

  // next pc: load beats increment, increment beats hold
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + 1'b1;
    end
  end

  // pc flop with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch sequencer between the 16-entry program memory and the
// decoder. Owns the pc, registers the fetched instruction and presents it
// over a valid/ready handshake.
// Optional macro PROG_FETCH_WRAP_HALT_EN: halt instead of wrapping past the
// last address, flagged on the wrap_halt output.
//
//   state | meaning
//   IDLE  | no fetch, waiting for start
//   RUN   | fetching one instruction per open slot
//   HALT  | no fetch, last instruction held until consumed
module prog_fetch_ctrl
  import prog_fetch_pkg::*;
#(
  parameter int ADDR_W = PROG_ADDR_W,
  parameter int DATA_W = PROG_DATA_W,
  parameter int unsigned RESET_PC = 0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = PROG_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              running,
`ifdef PROG_FETCH_WRAP_HALT_EN
  output logic              wrap_halt,
`endif
  output logic              halted
);

  localparam logic [1:0] S_IDLE = FS_IDLE;
  localparam logic [1:0] S_RUN  = FS_RUN;
  localparam logic [1:0] S_HALT = FS_HALT;
  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
`ifdef PROG_FETCH_WRAP_HALT_EN
  localparam logic [ADDR_W-1:0] PC_MAX = '1;
`endif

  logic [1:0]        state_d, state_q;
  logic [DATA_W-1:0] instr_d, instr_q;
  logic              valid_d, valid_q;
  logic [ADDR_W-1:0] pc_out_d, pc_out_q;
  logic              wrap_halt_d, wrap_halt_q;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc;
  logic              slot;

  prog_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // a fetch slot opens in RUN whenever the output register is empty or being drained
  assign slot = (state_q == S_RUN) && (!valid_q || instr_ready);

  // next-state, instruction register and pc control; priority stop > start > jump > fetch
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    pc_out_d    = pc_out_q;
    wrap_halt_d = wrap_halt_q;
    pc_load     = 1'b0;
    pc_load_val = RESET_PC_V;
    pc_inc      = 1'b0;

    if (stop) begin
      state_d     = S_IDLE;
      valid_d     = 1'b0;
      wrap_halt_d = 1'b0;
    end else if (start && (state_q != S_RUN)) begin
      state_d     = S_RUN;
      valid_d     = 1'b0;
      wrap_halt_d = 1'b0;
      pc_load     = 1'b1;
      pc_load_val = RESET_PC_V;
    end else if (state_q == S_RUN) begin
      if (jump_valid) begin
        // any handshake this cycle still completes; the pending fetch is dropped
        valid_d     = 1'b0;
        pc_load     = 1'b1;
        pc_load_val = jump_target;
      end else if (slot) begin
        instr_d  = mem_rdata;
        pc_out_d = pc;
        valid_d  = 1'b1;
        if (mem_rdata == HALT_OPCODE) begin
          state_d = S_HALT;
`ifdef PROG_FETCH_WRAP_HALT_EN
        end else if (pc == PC_MAX) begin
          state_d     = S_HALT;
          wrap_halt_d = 1'b1;
`endif
        end else begin
          pc_inc = 1'b1;
        end
      end
    end else if (valid_q && instr_ready) begin
      valid_d = 1'b0;
    end
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      pc_out_q    <= '0;
      wrap_halt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      pc_out_q    <= pc_out_d;
      wrap_halt_q <= wrap_halt_d;
    end
  end

  assign mem_addr    = pc;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign running     = (state_q == S_RUN);
  assign halted      = (state_q == S_HALT);
`ifdef PROG_FETCH_WRAP_HALT_EN
  assign wrap_halt   = wrap_halt_q;
`else
  logic unused_wrap_halt;
  assign unused_wrap_halt = wrap_halt_q;
`endif

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Directed bench for prog_fetch_ctrl: a vector table for the main sequence
// plus hand-written sequences for streaming, halt and wrap behaviour.
module tb_prog_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop, jump_valid, instr_ready;
  logic [3:0] jump_target, mem_addr, pc_out;
  logic [7:0] mem_rdata, instr;
  logic       instr_valid, running, halted;
`ifdef PROG_FETCH_WRAP_HALT_EN
  logic       wrap_halt;
`endif

  logic [7:0] mem [16];
  assign mem_rdata = mem[mem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  prog_fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_out      (pc_out),
    .running     (running),
`ifdef PROG_FETCH_WRAP_HALT_EN
    .wrap_halt   (wrap_halt),
`endif
    .halted      (halted)
  );

  typedef struct {
    logic       rst, start, stop, jv;
    logic [3:0] jt;
    logic       rdy;
    logic       ev;
    logic [7:0] ei;
    logic [3:0] epo, ea;
    logic       er, eh;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic r, logic s, logic p, logic j, logic [3:0] t, logic y,
                              logic v, logic [7:0] i, logic [3:0] po, logic [3:0] a,
                              logic ru, logic h);
    vec_t x;
    x.rst = r; x.start = s; x.stop = p; x.jv = j; x.jt = t; x.rdy = y;
    x.ev = v; x.ei = i; x.epo = po; x.ea = a; x.er = ru; x.eh = h;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input logic j,
                       input logic [3:0] t, input logic y);
    rst = r; start = s; stop = p; jump_valid = j; jump_target = t; instr_ready = y;
  endtask

  // advance one rising edge and settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [7:0] i,
                            input logic [3:0] po, input logic [3:0] a,
                            input logic ru, input logic h);
    chk({tag, ".valid"}, int'(instr_valid), int'(v));
    if (v) begin
      chk({tag, ".instr"}, int'(instr), int'(i));
      chk({tag, ".pc_out"}, int'(pc_out), int'(po));
    end
    chk({tag, ".mem_addr"}, int'(mem_addr), int'(a));
    chk({tag, ".running"}, int'(running), int'(ru));
    chk({tag, ".halted"}, int'(halted), int'(h));
  endtask

  initial begin
    for (int k = 0; k < 15; k++) mem[k] = 8'h10 + 8'(k);
    mem[15] = 8'hFF;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    chk("rst.instr", int'(instr), 0);
    chk("rst.pc_out", int'(pc_out), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step();
      expect_all($sformatf("idle%0d", c), 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    end

    //            rst  st   sp   jv   jt    rdy  |  v    instr  po    addr  run  halt
    vt[0]  = mk(1'b1,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b0,8'h00,4'd0, 4'd0, 1'b0,1'b0);
    vt[1]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b0,8'h00,4'd0, 4'd0, 1'b0,1'b0);
    vt[2]  = mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b0,8'h00,4'd0, 4'd0, 1'b1,1'b0);
    vt[3]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,8'h10,4'd0, 4'd1, 1'b1,1'b0);
    vt[4]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,8'h10,4'd0, 4'd1, 1'b1,1'b0);
    vt[5]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,8'h10,4'd0, 4'd1, 1'b1,1'b0);
    vt[6]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b1,8'h10,4'd0, 4'd1, 1'b1,1'b0);
    vt[7]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h11,4'd1, 4'd2, 1'b1,1'b0);
    vt[8]  = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h12,4'd2, 4'd3, 1'b1,1'b0);
    vt[9]  = mk(1'b0,1'b0,1'b0,1'b1,4'd9,1'b1, 1'b0,8'h12,4'd2, 4'd9, 1'b1,1'b0);
    vt[10] = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h19,4'd9, 4'd10,1'b1,1'b0);
    vt[11] = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h1A,4'd10,4'd11,1'b1,1'b0);
    vt[12] = mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b1,8'h1A,4'd10,4'd11,1'b1,1'b0);
    vt[13] = mk(1'b0,1'b0,1'b0,1'b1,4'd4,1'b1, 1'b0,8'h1A,4'd10,4'd4, 1'b1,1'b0);
    vt[14] = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h14,4'd4, 4'd5, 1'b1,1'b0);
    vt[15] = mk(1'b0,1'b0,1'b1,1'b0,4'd0,1'b1, 1'b0,8'h14,4'd4, 4'd5, 1'b0,1'b0);
    vt[16] = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b0, 1'b0,8'h14,4'd4, 4'd5, 1'b0,1'b0);
    vt[17] = mk(1'b0,1'b1,1'b0,1'b0,4'd0,1'b0, 1'b0,8'h14,4'd4, 4'd0, 1'b1,1'b0);
    vt[18] = mk(1'b0,1'b0,1'b0,1'b0,4'd0,1'b1, 1'b1,8'h10,4'd0, 4'd1, 1'b1,1'b0);

    for (int n = 0; n < 19; n++) begin
      drive(vt[n].rst, vt[n].start, vt[n].stop, vt[n].jv, vt[n].jt, vt[n].rdy);
      step();
      expect_all($sformatf("vec%0d", n), vt[n].ev, vt[n].ei, vt[n].epo, vt[n].ea,
                 vt[n].er, vt[n].eh);
    end

    // stream the rest of memory into the halt opcode at address 15
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int k = 1; k < 15; k++) begin
      step();
      expect_all($sformatf("stream%0d", k), 1'b1, 8'h10 + 8'(k), 4'(k), 4'(k + 1),
                 1'b1, 1'b0);
    end
    step();
    expect_all("halt_cap", 1'b1, 8'hFF, 4'd15, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    expect_all("halt_hold", 1'b1, 8'hFF, 4'd15, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    expect_all("halt_drain", 1'b0, 8'hFF, 4'd15, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1);
    step();
    expect_all("halt_jump_ign", 1'b0, 8'hFF, 4'd15, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1);
    step();
    expect_all("halt_start_jump", 1'b0, 8'hFF, 4'd15, 4'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    expect_all("restart0", 1'b1, 8'h10, 4'd0, 4'd1, 1'b1, 1'b0);

    // no halt opcode anywhere: check the last-address behaviour
    mem[15] = 8'h1F;
    for (int k = 1; k < 15; k++) begin
      step();
      expect_all($sformatf("wstream%0d", k), 1'b1, 8'h10 + 8'(k), 4'(k), 4'(k + 1),
                 1'b1, 1'b0);
    end
    step();
`ifdef PROG_FETCH_WRAP_HALT_EN
    expect_all("wrap15", 1'b1, 8'h1F, 4'd15, 4'd15, 1'b0, 1'b1);
    chk("wrap_halt_set", int'(wrap_halt), 1);
    step();
    expect_all("wrap_drain", 1'b0, 8'h1F, 4'd15, 4'd15, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    chk("wrap_halt_clr", int'(wrap_halt), 0);
    expect_all("wrap_restart", 1'b0, 8'h1F, 4'd15, 4'd0, 1'b1, 1'b0);
`else
    expect_all("wrap15", 1'b1, 8'h1F, 4'd15, 4'd0, 1'b1, 1'b0);
    step();
    expect_all("wrap0", 1'b1, 8'h10, 4'd0, 4'd1, 1'b1, 1'b0);
    step();
    expect_all("wrap1", 1'b1, 8'h11, 4'd1, 4'd2, 1'b1, 1'b0);
`endif

    // synchronous reset in mid-stream
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    expect_all("rst_mid", 1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("rst_mid.instr", int'(instr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_fetch_ctrl.md
Name: prog_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 16-entry x 8-bit program memory.
- Owns the program counter and drives the memory address.
- Captures the memory read data into an output instruction register.
- Hands instructions to the decoder over a valid/ready handshake.
- Handles jumps, start/stop and halt-opcode detection.
- Sits between the program memory and the instruction decoder.

Parameters:
ADDR_W, 4, program-memory address width (16 entries)
DATA_W, 8, instruction width
RESET_PC, 0, PC loaded on start
HALT_OPCODE, 8'hFF, instruction value that halts fetch

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; begin fetching from RESET_PC (honoured in IDLE or HALT)
stop  input  1  pulse; abort fetch, flush, go to IDLE
jump_valid  input  1  redirect PC this cycle
jump_target  input  ADDR_W  new PC
mem_addr  output  ADDR_W  address to program memory, equals pc register
mem_rdata  input  DATA_W  combinational read data for mem_addr
instr  output  DATA_W  registered instruction
instr_valid  output  1  instr holds an unconsumed instruction
instr_ready  input  1  decoder accepts instr when instr_valid & instr_ready
pc_out  output  ADDR_W  address of instruction currently in instr
running  output  1  state==RUN
halted  output  1  state==HALT

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, pc_out=0. rst overrides all other inputs.
- States:
  - IDLE: no fetch. start -> RUN with pc=RESET_PC.
  - RUN: fetch active.
  - HALT: no fetch, instr and instr_valid held until consumed. start -> RUN with pc=RESET_PC and instr_valid cleared.
- Fetch slot (RUN): a slot opens when !instr_valid or (instr_valid & instr_ready). In that slot:
  - instr<=mem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+1 modulo 2^ADDR_W (15 wraps to 0).
  - Throughput 1 instr/cycle under continuous ready.
  - Latency: address to instr_valid is 1 cycle.
- Stall: instr_valid & !instr_ready -> instr, pc_out and pc are held stable.
- Halt detection: if the fetched mem_rdata==HALT_OPCODE:
  - The opcode is still captured and presented (instr_valid=1); pc is not incremented.
  - Next state is HALT.
  - Once it is consumed, instr_valid=0.
- Jump (RUN only; ignored in IDLE/HALT):
  - pc<=jump_target and instr_valid<=0 (flush). No fetch slot that cycle.
  - First instruction from jump_target is valid 2 cycles after jump_valid.
  - A handshake coinciding with jump_valid counts as consumed; the fetch is then flushed.
- Stop (any state): state<=IDLE, instr_valid<=0, pc unchanged.
- Priority, highest first: rst > stop > start (IDLE/HALT only; ignored in RUN) > jump > fetch slot.
- start and jump in the same cycle while in HALT: start wins, jump ignored.
- mem_addr is a pure function of the pc register (no combinational path from inputs).

Optional Feature:
PROG_FETCH_WRAP_HALT_EN
- Defined: a fetch slot at pc=2^ADDR_W-1 captures the instruction, then enters HALT instead of wrapping.
  - Adds output wrap_halt (1 bit). It is set with that transition, cleared on start/stop/rst.
  - A jump still reaches any address.
- Undefined: pc wraps 15->0 silently; no wrap_halt port.

Decomposition:
- Package prog_fetch_pkg holds:
  - the state enum {IDLE, RUN, HALT} as fetch_state_t;
  - default constants PROG_ADDR_W=4, PROG_DATA_W=8, PROG_HALT_OPCODE=8'hFF;
  - type aliases pc_t and instr_t.
- One natural sub-module, prog_pc_reg: the pc register with synchronous load (start/jump), increment enable and hold. The FSM and instruction register stay in prog_fetch_ctrl.

Test Plan:
- Reset then idle: rst 1 cycle, no start -> instr_valid=0, mem_addr=0, running=0 for 10 cycles; with rst high, start is ignored.
- Streaming fetch: memory 0..14 = 8'h10+i, 15=8'hFF; start, ready=1 -> instr 8'h10..8'h1E on consecutive cycles with pc_out 0..14, then 8'hFF at pc_out=15, halted=1, pc stays 15.
- Backpressure: ready=0 for 3 cycles after first valid -> instr=8'h10, pc_out=0 held 3 cycles, mem_addr=1 held; ready=1 -> 8'h11 next.
- Jump: jump_valid with target=9 while instr=8'h12 valid -> next cycle instr_valid=0, mem_addr=9; following cycle instr=8'h19, pc_out=9; simultaneous handshake counts 8'h12 consumed.
- Stop/restart: stop mid-stream at pc=5 -> IDLE, instr_valid=0 next cycle, mem_addr=5; start -> first instr from address 0; start during RUN has no effect.
- Wrap: no HALT_OPCODE in memory -> without macro instr sequence …15,0,1 with pc_out wrapping; with PROG_FETCH_WRAP_HALT_EN, entry 15 is delivered, then halted=1, wrap_halt=1.
